// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: one-hot permit to the output buffers, zero-latency grant.
// Optional starvation watchdog enabled by defining CDB_ARB_STARVATION_CHECK_EN.
module cdb_arbiter #(
    parameter int unsigned N_REQUESTERS = 3,
    parameter int unsigned MAX_WAIT     = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [N_REQUESTERS-1:0]         request,
    input  logic                            hold,
    output logic [N_REQUESTERS-1:0]         permit,
    output logic                            cdb_valid,
    output logic [$clog2(N_REQUESTERS)-1:0] grant_index,
    output logic                            starvation_error
);

    localparam int unsigned IW = $clog2(N_REQUESTERS);
    localparam logic [IW-1:0] LAST = IW'(N_REQUESTERS - 1);

    if (N_REQUESTERS < 2 || MAX_WAIT < 1) begin : g_param_check
        $error("cdb_arbiter: N_REQUESTERS must be >= 2 and MAX_WAIT >= 1");
    end

    logic [IW-1:0]           r_ptr;
    logic [N_REQUESTERS-1:0] w_permit;
    logic [IW-1:0]           w_gidx;
    logic                    w_found;

    // Rotating scan split into two passes: ptr..N-1, then 0..ptr-1.
    always_comb begin
        w_permit = '0;
        w_gidx   = '0;
        w_found  = 1'b0;
        for (int unsigned i = 0; i < N_REQUESTERS; i++) begin
            if (!w_found && i >= 32'(r_ptr) && request[i]) begin
                w_found     = 1'b1;
                w_permit[i] = 1'b1;
                w_gidx      = IW'(i);
            end
        end
        for (int unsigned i = 0; i < N_REQUESTERS; i++) begin
            if (!w_found && i < 32'(r_ptr) && request[i]) begin
                w_found     = 1'b1;
                w_permit[i] = 1'b1;
                w_gidx      = IW'(i);
            end
        end
        if (reset || hold) begin
            w_permit = '0;
            w_gidx   = '0;
            w_found  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= (w_gidx == LAST) ? '0 : w_gidx + 1'b1;
        end
    end

    assign permit      = w_permit;
    assign cdb_valid   = w_found;
    assign grant_index = w_gidx;

`ifdef CDB_ARB_STARVATION_CHECK_EN
    localparam int unsigned CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WMAX = CW'(MAX_WAIT);

    logic [CW-1:0] r_wait [N_REQUESTERS];
    logic          r_starve;
    logic          w_hit;

    always_comb begin
        w_hit = 1'b0;
        for (int unsigned i = 0; i < N_REQUESTERS; i++) begin
            if (r_wait[i] == WMAX) w_hit = 1'b1;
        end
    end

    // Counters freeze during hold so a flush never looks like starvation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_REQUESTERS; i++) r_wait[i] <= '0;
            r_starve <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < N_REQUESTERS; i++) begin
                if (w_permit[i] || !request[i]) begin
                    r_wait[i] <= '0;
                end else if (!hold && r_wait[i] != WMAX) begin
                    r_wait[i] <= r_wait[i] + 1'b1;
                end
            end
            if (w_hit) r_starve <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < N_REQUESTERS; i++) begin
            if (!reset && !r_starve && r_wait[i] == WMAX)
                $error("cdb_arbiter: requester %0d starved for %0d cycles", i, MAX_WAIT);
        end
    end
`endif

    assign starvation_error = r_starve;
`else
    assign starvation_error = 1'b0;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed round-robin/hold/reset cases, then random traffic.
module tb_cdb_arbiter;

    localparam int unsigned N = 3;

    logic         clk;
    logic         reset;
    logic [N-1:0] request;
    logic         hold;
    logic [N-1:0] permit;
    logic         cdb_valid;
    logic [1:0]   grant_index;
    logic         starvation_error;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned m_ptr = 0;

    typedef struct {
        string        tag;
        logic [N-1:0] p;
    } item_t;
    item_t sbq[$];

    cdb_arbiter #(
        .N_REQUESTERS(N),
        .MAX_WAIT    (16)
    ) u_dut (
        .clk             (clk),
        .reset           (reset),
        .request         (request),
        .hold            (hold),
        .permit          (permit),
        .cdb_valid       (cdb_valid),
        .grant_index     (grant_index),
        .starvation_error(starvation_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned onehot_idx(input logic [N-1:0] p);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < N; i++) if (p[i]) r = i;
        return r;
    endfunction

    function automatic logic [N-1:0] model_permit(input logic [N-1:0] req, input logic hld,
                                                  input logic rst, input int unsigned ptr);
        logic [N-1:0] r;
        int unsigned  idx;
        r = '0;
        if (!hld && !rst) begin
            for (int unsigned k = 0; k < N; k++) begin
                idx = (ptr + k) % N;
                if (r == '0 && req[idx]) r[idx] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic run_cycle(input string tag, input logic [N-1:0] req, input logic hld,
                             input logic [N-1:0] exp_p);
        item_t it;
        @(posedge clk);
        #1;
        request = req;
        hold    = hld;
        it.tag  = tag;
        it.p    = exp_p;
        sbq.push_back(it);
        @(negedge clk);
        it = sbq.pop_front();
        check({it.tag, "_permit"}, 32'(permit), 32'(it.p));
        check({it.tag, "_valid"}, 32'(cdb_valid), 32'(|it.p));
        check({it.tag, "_gidx"}, 32'(grant_index), onehot_idx(it.p));
`ifndef CDB_ARB_STARVATION_CHECK_EN
        check({it.tag, "_starve"}, 32'(starvation_error), 32'd0);
`endif
        if (it.p != '0) m_ptr = (onehot_idx(it.p) + 1) % N;
    endtask

    task automatic run_model(input string tag, input logic [N-1:0] req, input logic hld);
        run_cycle(tag, req, hld, model_permit(req, hld, reset, m_ptr));
    endtask

    initial begin
        logic [N-1:0] rr_seq [6];
        rr_seq[0] = 3'b001; rr_seq[1] = 3'b010; rr_seq[2] = 3'b100;
        rr_seq[3] = 3'b001; rr_seq[4] = 3'b010; rr_seq[5] = 3'b100;

        reset   = 1'b1;
        request = '0;
        hold    = 1'b0;

        run_cycle("t1_in_reset", 3'b000, 1'b0, 3'b000);
        run_cycle("t1_in_reset_req", 3'b111, 1'b0, 3'b000);
        request = '0;
        @(negedge clk);
        reset = 1'b0;
        run_cycle("t1_idle", 3'b000, 1'b0, 3'b000);
        run_cycle("t1_idle2", 3'b000, 1'b0, 3'b000);

        for (int i = 0; i < 6; i++) run_cycle($sformatf("t2_rr%0d", i), 3'b111, 1'b0, rr_seq[i]);

        for (int i = 0; i < 3; i++) run_cycle($sformatf("t3_single%0d", i), 3'b010, 1'b0, 3'b010);

        run_cycle("t4_wrap", 3'b011, 1'b0, 3'b001);
        run_cycle("t4_next", 3'b011, 1'b0, 3'b010);

        for (int i = 0; i < 3; i++) run_cycle($sformatf("t5_hold%0d", i), 3'b111, 1'b1, 3'b000);
        run_cycle("t5_resume", 3'b111, 1'b0, 3'b100);

        run_cycle("t6_a", 3'b111, 1'b0, 3'b001);
        run_cycle("t6_b", 3'b111, 1'b0, 3'b010);
        run_cycle("t6_pre", 3'b111, 1'b0, 3'b100);
        #2;
        reset = 1'b1;
        #1;
        check("t6_mid_permit", 32'(permit), 32'd0);
        check("t6_mid_valid", 32'(cdb_valid), 32'd0);
        check("t6_mid_gidx", 32'(grant_index), 32'd0);
        request = '0;
        m_ptr   = 0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        run_cycle("t6_post", 3'b101, 1'b0, 3'b001);
        run_cycle("t6_post2", 3'b101, 1'b0, 3'b100);

        for (int i = 0; i < 200; i++) begin
            run_model($sformatf("rnd%0d", i), N'($urandom_range(0, 7)), ($urandom_range(0, 4) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
